// File: rtl/term_mode_pkg.sv
// Shared types and decode helpers for the terminal mode register with save stack.
package term_mode_pkg;

   localparam int unsigned MODE_W_DEF = 8;
   localparam int unsigned PN_W_DEF   = 12;
   localparam logic [7:0]  RESET_MODE_DEF = 8'h32;

   localparam int unsigned MODE_ORIGIN      = 0;
   localparam int unsigned MODE_AUTO_WRAP   = 1;
   localparam int unsigned MODE_INSERT      = 2;
   localparam int unsigned MODE_LINE_FEED   = 3;
   localparam int unsigned MODE_CURSOR_BLNK = 4;
   localparam int unsigned MODE_CURSOR_VIS  = 5;
   localparam int unsigned MODE_REVERSE     = 6;

   // Parser command encoding (mirrors the shared DataType header)
   typedef enum logic [3:0] {
      CMD_NONE   = 4'd0,
      INIT_PN    = 4'd1,
      EMIT_PN    = 4'd2,
      SETMODE    = 4'd3,
      RESETMODE  = 4'd4,
      SETDEC     = 4'd5,
      RESETDEC   = 4'd6,
      SAVEDEC    = 4'd7,
      RESTOREDEC = 4'd8,
      QUERYMODE  = 4'd9,
      QUERYDEC   = 4'd10
   } CommandsType;

   typedef enum logic [1:0] {
      STS_UNKNOWN = 2'd0,
      STS_SET     = 2'd1,
      STS_RESET   = 2'd2
   } reply_status_t;

   typedef enum logic [1:0] {
      APPLY_NONE,
      APPLY_SET,
      APPLY_RESET,
      APPLY_RESTORE
   } apply_op_t;

   typedef struct packed {
      logic [MODE_W_DEF-1:0] bits;
      logic [MODE_W_DEF-1:0] mask;
   } mode_entry_t;

   function automatic logic [7:0] decode_ansi(input int unsigned pn);
      logic [7:0] m;
      m = '0;
      case (pn)
         32'd4:   m[MODE_INSERT]    = 1'b1;
         32'd20:  m[MODE_LINE_FEED] = 1'b1;
         default: ;
      endcase
      return m;
   endfunction

   function automatic logic [7:0] decode_dec(input int unsigned pn);
      logic [7:0] m;
      m = '0;
      case (pn)
         32'd5:   m[MODE_REVERSE]     = 1'b1;
         32'd6:   m[MODE_ORIGIN]      = 1'b1;
         32'd7:   m[MODE_AUTO_WRAP]   = 1'b1;
         32'd12:  m[MODE_CURSOR_BLNK] = 1'b1;
         32'd25:  m[MODE_CURSOR_VIS]  = 1'b1;
         default: ;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/term_mode_stack_if.sv
// Parser command stream and DECRQM reply channel for term_mode_stack.
interface term_mode_stack_if
   import term_mode_pkg::*;
#(
   parameter int unsigned PN_W = PN_W_DEF
) ();
   logic            cmd_valid;
   CommandsType     cmd_type;
   logic [PN_W-1:0] cmd_pn;
   logic            reply_valid;
   logic            reply_ready;
   logic [PN_W-1:0] reply_pn;
   logic            reply_dec;
   logic [1:0]      reply_status;

   modport master (
      output cmd_valid, cmd_type, cmd_pn, reply_ready,
      input  reply_valid, reply_pn, reply_dec, reply_status
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_pn, reply_ready,
      output reply_valid, reply_pn, reply_dec, reply_status
   );
endinterface

// File: rtl/mode_save_stack.sv
// Circular LIFO for saved DEC mode entries; a push on a full stack overwrites the oldest.
module mode_save_stack #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  logic [2*W-1:0] push_data,
   output logic [2*W-1:0] top_data,
   output logic           empty,
   output logic           overflow
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [2*W-1:0] mem_q [DEPTH];
   logic [2*W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] top_q, top_d;
   logic [PTR_W:0]   count_q, count_d;

   // top_q is the next free slot; wrapping it lets a full push land on the oldest entry
   always_comb begin
      mem_d    = mem_q;
      top_d    = top_q;
      count_d  = count_q;
      overflow = 1'b0;
      if (push) begin
         mem_d[top_q] = push_data;
         top_d        = top_q + PTR_W'(1);
         if (count_q == (PTR_W+1)'(DEPTH)) overflow = 1'b1;
         else                              count_d  = count_q + (PTR_W+1)'(1);
      end else if (pop && count_q != '0) begin
         top_d   = top_q - PTR_W'(1);
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   assign top_data = mem_q[top_q - PTR_W'(1)];
   assign empty    = (count_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         top_q   <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         top_q   <= top_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/term_mode_stack.sv
// Terminal mode register with SM/RM, DEC set/reset, XTSAVE/XTRESTORE stack.
// Optional DECRQM reply channel enabled by macro MODE_QUERY_EN.
module term_mode_stack
   import term_mode_pkg::*;
#(
   parameter int unsigned       MODE_W      = MODE_W_DEF,
   parameter int unsigned       PN_W        = PN_W_DEF,
   parameter int unsigned       STACK_DEPTH = 4,
   parameter logic [MODE_W-1:0] RESET_MODE  = MODE_W'(RESET_MODE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   term_mode_stack_if.slave  bus,
   output logic [MODE_W-1:0] term_mode,
   output logic              stack_overflow
);
   typedef struct packed {
      logic [MODE_W-1:0] bits;
      logic [MODE_W-1:0] mask;
   } entry_t;

   logic [MODE_W-1:0] term_mode_q, term_mode_d;
   logic [MODE_W-1:0] ansi_mask_q, ansi_mask_d;
   logic [MODE_W-1:0] dec_mask_q, dec_mask_d;
   logic [MODE_W-1:0] apply_mask_q, apply_mask_d;
   logic [MODE_W-1:0] apply_bits_q, apply_bits_d;
   apply_op_t         apply_op_q, apply_op_d;
   logic              stack_overflow_q, stack_overflow_d;
   logic [MODE_W-1:0] pn_ansi, pn_dec, eff_ansi, eff_dec;
   logic              push, pop, stk_empty, stk_ovf;
   entry_t            push_entry, top_entry;

   assign pn_ansi  = MODE_W'(decode_ansi(32'(bus.cmd_pn)));
   assign pn_dec   = MODE_W'(decode_dec(32'(bus.cmd_pn)));
   assign eff_ansi = ansi_mask_q | pn_ansi;
   assign eff_dec  = dec_mask_q | pn_dec;

   // Latched terminator completes here, one edge after it was accepted
   always_comb begin
      term_mode_d = term_mode_q;
      case (apply_op_q)
         APPLY_SET:     term_mode_d = term_mode_q | apply_mask_q;
         APPLY_RESET:   term_mode_d = term_mode_q & ~apply_mask_q;
         APPLY_RESTORE: term_mode_d = (term_mode_q & ~apply_mask_q) | apply_bits_q;
         default:       ;
      endcase
   end

   always_comb begin
      ansi_mask_d      = ansi_mask_q;
      dec_mask_d       = dec_mask_q;
      apply_op_d       = APPLY_NONE;
      apply_mask_d     = '0;
      apply_bits_d     = '0;
      push             = 1'b0;
      pop              = 1'b0;
      push_entry.bits  = term_mode_d & eff_dec;
      push_entry.mask  = eff_dec;
      stack_overflow_d = stack_overflow_q | stk_ovf;
      if (bus.cmd_valid) begin
         case (bus.cmd_type)
            INIT_PN: begin
               ansi_mask_d = '0;
               dec_mask_d  = '0;
            end
            EMIT_PN: begin
               ansi_mask_d = eff_ansi;
               dec_mask_d  = eff_dec;
            end
            SETMODE, RESETMODE: begin
               apply_op_d   = (bus.cmd_type == SETMODE) ? APPLY_SET : APPLY_RESET;
               apply_mask_d = eff_ansi;
            end
            SETDEC, RESETDEC: begin
               apply_op_d   = (bus.cmd_type == SETDEC) ? APPLY_SET : APPLY_RESET;
               apply_mask_d = eff_dec;
            end
            SAVEDEC: push = 1'b1;
            RESTOREDEC: begin
               if (!stk_empty) begin
                  pop          = 1'b1;
                  apply_op_d   = APPLY_RESTORE;
                  apply_mask_d = top_entry.mask;
                  apply_bits_d = top_entry.bits;
               end
            end
            default: ;
         endcase
      end
   end

   mode_save_stack #(
      .W     (MODE_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (push_entry),
      .top_data  (top_entry),
      .empty     (stk_empty),
      .overflow  (stk_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         term_mode_q      <= RESET_MODE;
         ansi_mask_q      <= '0;
         dec_mask_q       <= '0;
         apply_op_q       <= APPLY_NONE;
         apply_mask_q     <= '0;
         apply_bits_q     <= '0;
         stack_overflow_q <= 1'b0;
      end else begin
         term_mode_q      <= term_mode_d;
         ansi_mask_q      <= ansi_mask_d;
         dec_mask_q       <= dec_mask_d;
         apply_op_q       <= apply_op_d;
         apply_mask_q     <= apply_mask_d;
         apply_bits_q     <= apply_bits_d;
         stack_overflow_q <= stack_overflow_d;
      end
   end

   assign term_mode      = term_mode_q;
   assign stack_overflow = stack_overflow_q;

`ifdef MODE_QUERY_EN
   logic              reply_valid_q, reply_valid_d;
   logic [PN_W-1:0]   reply_pn_q, reply_pn_d;
   logic              reply_dec_q, reply_dec_d;
   reply_status_t     reply_status_q, reply_status_d;
   logic [MODE_W-1:0] q_mask;

   // A query is dropped whenever a reply is still outstanding, even on its handshake cycle
   always_comb begin
      reply_valid_d  = reply_valid_q;
      reply_pn_d     = reply_pn_q;
      reply_dec_d    = reply_dec_q;
      reply_status_d = reply_status_q;
      q_mask         = (bus.cmd_type == QUERYDEC) ? pn_dec : pn_ansi;
      if (reply_valid_q && bus.reply_ready) reply_valid_d = 1'b0;
      if (bus.cmd_valid && !reply_valid_q &&
          (bus.cmd_type == QUERYMODE || bus.cmd_type == QUERYDEC)) begin
         reply_valid_d = 1'b1;
         reply_pn_d    = bus.cmd_pn;
         reply_dec_d   = (bus.cmd_type == QUERYDEC);
         if (q_mask == '0)                      reply_status_d = STS_UNKNOWN;
         else if ((term_mode_d & q_mask) != '0) reply_status_d = STS_SET;
         else                                   reply_status_d = STS_RESET;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reply_valid_q  <= 1'b0;
         reply_pn_q     <= '0;
         reply_dec_q    <= 1'b0;
         reply_status_q <= STS_UNKNOWN;
      end else begin
         reply_valid_q  <= reply_valid_d;
         reply_pn_q     <= reply_pn_d;
         reply_dec_q    <= reply_dec_d;
         reply_status_q <= reply_status_d;
      end
   end

   assign bus.reply_valid  = reply_valid_q;
   assign bus.reply_pn     = reply_pn_q;
   assign bus.reply_dec    = reply_dec_q;
   assign bus.reply_status = reply_status_q;
`else
   logic unused_reply_ready;
   assign unused_reply_ready = bus.reply_ready;
   assign bus.reply_valid    = 1'b0;
   assign bus.reply_pn       = PN_W'(0);
   assign bus.reply_dec      = 1'b0;
   assign bus.reply_status   = '0;
`endif
endmodule

// File: tb/tb_term_mode_stack.sv
// Scoreboard bench for term_mode_stack; query checks follow MODE_QUERY_EN.
module tb_term_mode_stack;
   import term_mode_pkg::*;

   typedef struct {
      logic [11:0] pn;
      logic        dec;
      logic [1:0]  st;
   } rep_t;

   logic       clk;
   logic       rst;
   logic [7:0] term_mode;
   logic       stack_overflow;

   term_mode_stack_if #(.PN_W(12)) bus ();

   term_mode_stack #(
      .MODE_W      (8),
      .PN_W        (12),
      .STACK_DEPTH (4),
      .RESET_MODE  (8'h32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .term_mode      (term_mode),
      .stack_overflow (stack_overflow)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [7:0]  m_mode, m_ansi, m_dec;
   logic        m_ovf;
   logic [15:0] m_stack [$];
   logic [7:0]  exp_q [$];
   rep_t        rq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] tb_ansi(input int unsigned pn);
      case (pn)
         4:       return 8'h04;
         20:      return 8'h08;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] tb_dec(input int unsigned pn);
      case (pn)
         5:       return 8'h40;
         6:       return 8'h01;
         7:       return 8'h02;
         12:      return 8'h10;
         25:      return 8'h20;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_cmd(input CommandsType t, input int unsigned pn);
      logic [7:0]  ea, ed;
      logic [15:0] e;
      ea = m_ansi | tb_ansi(pn);
      ed = m_dec | tb_dec(pn);
      case (t)
         INIT_PN:   begin m_ansi = 8'h00; m_dec = 8'h00; end
         EMIT_PN:   begin m_ansi = ea; m_dec = ed; end
         SETMODE:   m_mode = m_mode | ea;
         RESETMODE: m_mode = m_mode & ~ea;
         SETDEC:    m_mode = m_mode | ed;
         RESETDEC:  m_mode = m_mode & ~ed;
         SAVEDEC: begin
            m_stack.push_back({m_mode & ed, ed});
            if (m_stack.size() > 4) begin
               void'(m_stack.pop_front());
               m_ovf = 1'b1;
            end
         end
         RESTOREDEC: begin
            if (m_stack.size() > 0) begin
               e = m_stack.pop_back();
               m_mode = (m_mode & ~e[7:0]) | e[15:8];
            end
         end
         default: ;
      endcase
   endtask

   task automatic do_cmd(input CommandsType t, input int unsigned pn);
      bus.cmd_valid = 1'b1;
      bus.cmd_type  = t;
      bus.cmd_pn    = pn[11:0];
      model_cmd(t, pn);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_type  = CMD_NONE;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_mode = 8'h32; m_ansi = 8'h00; m_dec = 8'h00; m_ovf = 1'b0;
      m_stack.delete();
      exp_q.delete();
      rq.delete();
   endtask

   task automatic test_reset();
      logic [7:0] e;
      apply_reset();
      exp_q.push_back(8'h32);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL reset_mode: got %h want %h", term_mode, e); n_fail++;
      end
      n_tests++;
      if (stack_overflow !== 1'b0) begin
         $display("FAIL reset_ovf: got %b want 0", stack_overflow); n_fail++;
      end
      n_tests++;
      if (bus.reply_valid !== 1'b0) begin
         $display("FAIL reset_reply_valid: got %b want 0", bus.reply_valid); n_fail++;
      end
   endtask

   task automatic test_dec_ansi();
      logic [7:0] e;
      do_cmd(INIT_PN, 0);
      do_cmd(EMIT_PN, 6);
      do_cmd(RESETDEC, 25);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e || term_mode !== 8'h12) begin
         $display("FAIL resetdec_list: got %h want %h", term_mode, e); n_fail++;
      end
      do_cmd(SETDEC, 6);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e || term_mode !== 8'h13) begin
         $display("FAIL setdec_origin: got %h want %h", term_mode, e); n_fail++;
      end
      do_cmd(INIT_PN, 0);
      do_cmd(EMIT_PN, 20);
      do_cmd(SETMODE, 4);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL setmode_list: got %h want %h", term_mode, e); n_fail++;
      end
      do_cmd(INIT_PN, 0);
      do_cmd(RESETDEC, 99);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL unknown_pn: got %h want %h", term_mode, e); n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      apply_reset();
      do_cmd(INIT_PN, 0);
      do_cmd(SETMODE, 4);
      exp_q.push_back(m_mode);
      do_cmd(RESETMODE, 4);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e || term_mode[2] !== 1'b1) begin
         $display("FAIL b2b_first: got %h want %h", term_mode, e); n_fail++;
      end
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e || term_mode[2] !== 1'b0) begin
         $display("FAIL b2b_second: got %h want %h", term_mode, e); n_fail++;
      end
      // save on the edge where a set completes must capture the post-set value
      do_cmd(SETDEC, 6);
      do_cmd(SAVEDEC, 6);
      do_cmd(RESETDEC, 6);
      @(negedge clk);
      do_cmd(RESTOREDEC, 0);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL save_after_apply: got %h want %h", term_mode, e); n_fail++;
      end
   endtask

   task automatic test_save_restore();
      logic [7:0] e;
      apply_reset();
      do_cmd(INIT_PN, 0);
      do_cmd(SAVEDEC, 7);
      do_cmd(RESETDEC, 7);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e || term_mode !== 8'h30) begin
         $display("FAIL save_reset: got %h want %h", term_mode, e); n_fail++;
      end
      do_cmd(RESTOREDEC, 7);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e || term_mode !== 8'h32) begin
         $display("FAIL restore: got %h want %h", term_mode, e); n_fail++;
      end
   endtask

   task automatic test_overflow();
      logic [7:0] e;
      apply_reset();
      do_cmd(INIT_PN, 0);
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            n_tests++;
            if (stack_overflow !== m_ovf) begin
               $display("FAIL ovf_before_full: got %b want %b", stack_overflow, m_ovf); n_fail++;
            end
         end
         do_cmd(SAVEDEC, 7);
         if (k < 4) do_cmd((k % 2 == 0) ? RESETDEC : SETDEC, 7);
      end
      @(negedge clk);
      n_tests++;
      if (stack_overflow !== m_ovf || stack_overflow !== 1'b1) begin
         $display("FAIL ovf_set: got %b want %b", stack_overflow, m_ovf); n_fail++;
      end
      for (int k = 0; k < 5; k++) begin
         do_cmd(RESTOREDEC, 7);
         exp_q.push_back(m_mode);
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (term_mode !== e) begin
            $display("FAIL restore_%0d: got %h want %h", k, term_mode, e); n_fail++;
         end
      end
      n_tests++;
      if (stack_overflow !== 1'b1) begin
         $display("FAIL ovf_sticky: got %b want 1", stack_overflow); n_fail++;
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] e;
      apply_reset();
      do_cmd(INIT_PN, 0);
      do_cmd(EMIT_PN, 6);
      do_cmd(SAVEDEC, 25);
      do_cmd(RESETDEC, 25);
      apply_reset();
      @(negedge clk);
      exp_q.push_back(m_mode);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL mid_rst_pending: got %h want %h", term_mode, e); n_fail++;
      end
      do_cmd(RESETDEC, 99);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL mid_rst_masks: got %h want %h", term_mode, e); n_fail++;
      end
      do_cmd(RESTOREDEC, 25);
      exp_q.push_back(m_mode);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (term_mode !== e) begin
         $display("FAIL mid_rst_stack: got %h want %h", term_mode, e); n_fail++;
      end
   endtask

`ifdef MODE_QUERY_EN
   task automatic expect_reply(input string name);
      rep_t r;
      for (int i = 0; i < 4 && bus.reply_valid !== 1'b1; i++) @(negedge clk);
      r = rq.pop_front();
      n_tests++;
      if (bus.reply_valid !== 1'b1 || bus.reply_pn !== r.pn || bus.reply_dec !== r.dec ||
          bus.reply_status !== r.st) begin
         $display("FAIL %s: valid=%b pn=%0d dec=%b st=%0d want pn=%0d dec=%b st=%0d",
                  name, bus.reply_valid, bus.reply_pn, bus.reply_dec, bus.reply_status,
                  r.pn, r.dec, r.st);
         n_fail++;
      end
   endtask

   task automatic push_query(input CommandsType t, input int unsigned pn);
      rep_t       r;
      logic [7:0] m;
      m = (t == QUERYDEC) ? tb_dec(pn) : tb_ansi(pn);
      r.pn  = pn[11:0];
      r.dec = (t == QUERYDEC);
      r.st  = (m == 8'h00) ? 2'd0 : ((m_mode & m) != 8'h00) ? 2'd1 : 2'd2;
      rq.push_back(r);
   endtask

   task automatic handshake();
      bus.reply_ready = 1'b1;
      @(negedge clk);
      bus.reply_ready = 1'b0;
      n_tests++;
      if (bus.reply_valid !== 1'b0) begin
         $display("FAIL reply_drop: got valid=%b want 0", bus.reply_valid); n_fail++;
      end
   endtask

   task automatic test_query();
      apply_reset();
      bus.reply_ready = 1'b0;
      do_cmd(QUERYDEC, 25);
      push_query(QUERYDEC, 25);
      expect_reply("query_vis");
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.reply_valid !== 1'b1) begin
         $display("FAIL reply_hold: got valid=%b want 1", bus.reply_valid); n_fail++;
      end
      do_cmd(QUERYMODE, 4);
      @(negedge clk);
      n_tests++;
      if (bus.reply_pn !== 12'd25 || bus.reply_dec !== 1'b1 || bus.reply_status !== 2'd1) begin
         $display("FAIL query_dropped: pn=%0d dec=%b st=%0d want pn=25 dec=1 st=1",
                  bus.reply_pn, bus.reply_dec, bus.reply_status);
         n_fail++;
      end
      handshake();
      do_cmd(QUERYDEC, 99);
      push_query(QUERYDEC, 99);
      expect_reply("query_unknown");
      handshake();
      do_cmd(QUERYMODE, 4);
      push_query(QUERYMODE, 4);
      expect_reply("query_insert_reset");
      handshake();
      do_cmd(INIT_PN, 0);
      do_cmd(SETMODE, 4);
      push_query(QUERYMODE, 4);
      do_cmd(QUERYMODE, 4);
      expect_reply("query_same_edge");
      handshake();
   endtask
`else
   task automatic test_query();
      apply_reset();
      bus.reply_ready = 1'b0;
      do_cmd(QUERYDEC, 25);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (bus.reply_valid !== 1'b0 || bus.reply_status !== 2'd0 || bus.reply_pn !== 12'd0 ||
             bus.reply_dec !== 1'b0) begin
            $display("FAIL query_disabled: valid=%b st=%0d pn=%0d dec=%b want all 0",
                     bus.reply_valid, bus.reply_status, bus.reply_pn, bus.reply_dec);
            n_fail++;
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_type    = CMD_NONE;
      bus.cmd_pn      = 12'd0;
      bus.reply_ready = 1'b0;
      test_reset();
      test_dec_ansi();
      test_back_to_back();
      test_save_restore();
      test_overflow();
      test_mid_reset();
      test_query();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
